spi_reg_frontend: RTL
=====================

# spi_reg_frontend

Upstream configuration stage for the PWM peripheral: receives 16-bit SPI write frames on three asynchronous pad inputs (SCLK, COPI, nCS), resynchronises them into the system clock domain and decodes each frame. Valid writes update one of five 8-bit configuration registers that drive the PWM block's output-enable, PWM-enable and duty-cycle inputs directly. Write-only SPI mode 0, MSB first; no CIPO.

## Interface
Parameters:
- SYNC_STAGES, 2, flops per input synchroniser chain (≥2); an additional edge-detect flop follows on SCLK and nCS.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- sclk_in  in  1  SPI clock, asynchronous to clk.
- copi_in  in  1  SPI data, asynchronous.
- ncs_in  in  1  SPI chip select, active-low, asynchronous.
- en_reg_out_7_0  out  8  register 0x00.
- en_reg_out_15_8  out  8  register 0x01.
- en_reg_pwm_7_0  out  8  register 0x02.
- en_reg_pwm_15_8  out  8  register 0x03.
- pwm_duty_cycle  out  8  register 0x04.
- frame_done  out  1  one-cycle pulse: well-formed 16-bit frame ended.
- frame_err  out  1  one-cycle pulse: frame ended with bit count ≠ 16.

## Operation
- Synchronisers: reset values are SCLK chain 0, COPI chain 0, nCS chain 0 (asserted). Because nCS resets to asserted, a frame already in progress at reset release never produces a falling edge and is ignored.
- Edge detect: sclk_rise = synced SCLK 1 and delayed copy 0. ncs_fall and ncs_rise are defined the same way on nCS.
- Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data. COPI (synced) is sampled in the cycle sclk_rise is seen and shifted in LSB-side, so the first bit received lands in bit15.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE -> SHIFT on ncs_fall. On entry, clear the shift register and the bit counter.
- SHIFT:
  - Each sclk_rise shifts one bit in.
  - The bit counter saturates at 17; bits past 16 are discarded from the shift register.
  - ncs_rise -> COMMIT.
- COMMIT lasts one cycle, then -> IDLE. Decode:
  - count == 16, R/W = 1, address ≤ 0x04: write the data to the addressed register and pulse frame_done.
  - count == 16, R/W = 0: no write; pulse frame_done.
  - count == 16, address > 0x04: no write; pulse frame_done.
  - count ≠ 16 (including 0 and the saturated 17): no write; pulse frame_err.
- sclk_rise while in IDLE or COMMIT is ignored.
- If sclk_rise and ncs_rise occur in the same cycle, ncs_rise wins and that bit is dropped.
- Registers are written only in COMMIT and otherwise hold their value.
- Reset (any state, including mid-frame):
  - All five registers = 0x00.
  - frame_done = 0, frame_err = 0.
  - FSM -> IDLE; shift register and counter cleared.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Input latency: a pad edge appears on the synced signal SYNC_STAGES clk edges after it is first sampled, and the edge strobe is asserted in the following cycle.
- Write latency:
  - Edge k = first clk edge sampling ncs_in high.
  - FSM enters COMMIT at edge k+SYNC_STAGES.
  - Register output and frame_done/frame_err pulse change at edge k+SYNC_STAGES+1; with the default parameter this is edge k+3.
- Input constraints (the verification environment must honour these):
  - SCLK high and low phases ≥ SYNC_STAGES+1 clk periods each.
  - COPI stable from 1 clk period before to SYNC_STAGES+1 clk periods after each SCLK rise.
  - nCS high time between frames ≥ SYNC_STAGES+2 clk periods.
- Back-to-back frames that respect the nCS high time are never lost.

## Test plan
- Write to each address: frames 0x8055, 0x81AA, 0x820F, 0x83F0, 0x8480 -> registers 0x00–0x04 read 0x55, 0xAA, 0x0F, 0xF0, 0x80; five frame_done pulses; frame_err never asserts; each update lands 3 clk edges after nCS is sampled high.
- Read or out-of-range frames: frame 0x00FF, then frame 0x85FF -> every register is unchanged; exactly one frame_done pulse per frame.
- Short and long frames: 15 bits of 0x80FF, then 17 bits -> no register changes; one frame_err pulse per frame, no frame_done.
- Reset mid-frame: assert rst after 8 bits, release it while nCS is still low, finish the frame -> all registers 0x00, no pulses. The next complete frame 0x8422 sets pwm_duty_cycle = 0x22.
- Edge collision: the 16th SCLK rise is synced in the same cycle as the nCS rise -> the frame counts 15 bits, frame_err pulses, no write.
- Back-to-back: frames 0x8401 and 0x8402 separated by the minimum nCS high time -> pwm_duty_cycle goes 0x01 then 0x02; two frame_done pulses.

Source files
------------

// File: rtl/spi_reg_frontend.sv
// SPI write-only register front end for the PWM block.
// Resynchronises pad inputs and decodes 16-bit write frames into five registers.
module spi_reg_frontend #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       copi_in,
    input  logic       ncs_in,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_d, ncs_d;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    state_t          state_q, state_nxt;
    logic [15:0]     shift_q, shift_nxt;
    logic [4:0]      cnt_q, cnt_nxt;
    logic [4:0][7:0] cfg_q, cfg_nxt;
    logic            done_nxt, err_nxt;

    // nCS chain resets to asserted so an in-flight frame never sees a fall
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_in};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_in};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    always_comb begin
        state_nxt = state_q;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        cfg_nxt   = cfg_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_nxt = SHIFT;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_nxt = COMMIT;
                end else if (sclk_rise) begin
                    if (cnt_q < 5'd16)
                        shift_nxt = {shift_q[14:0], copi_s};
                    if (cnt_q < 5'd17)
                        cnt_nxt = cnt_q + 5'd1;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
                if (cnt_q == 5'd16) begin
                    done_nxt = 1'b1;
                    if (shift_q[15] && shift_q[14:8] <= 7'd4) begin
                        for (int i = 0; i < 5; i++)
                            if (shift_q[14:8] == 7'(i))
                                cfg_nxt[i] = shift_q[7:0];
                    end
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            cfg_q      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            shift_q    <= shift_nxt;
            cnt_q      <= cnt_nxt;
            cfg_q      <= cfg_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
        end
    end

    assign en_reg_out_7_0  = cfg_q[0];
    assign en_reg_out_15_8 = cfg_q[1];
    assign en_reg_pwm_7_0  = cfg_q[2];
    assign en_reg_pwm_15_8 = cfg_q[3];
    assign pwm_duty_cycle  = cfg_q[4];

endmodule
